cnn_inference_sequencer: RTL and testbench
==========================================

// Module: cnn_inference_sequencer
// PURPOSE
// - Runs one inference of the HLS CNN core (myproject, ap_ctrl_hs) per job.
// - Sits between the crop/normalise frame buffer and the result path.
// - On a job request, starts the core and streams one OUT_ROWSxOUT_COLS Mono8 crop from the buffer.
// - Captures the N_OUT x WORD_W prediction beat and extracts one FIELD_W field per word.
// - Holds the packed result until downstream accepts it.
// PARAMETERS
// - N_PIX      2304  pixels per crop (48x48)
// - ADDR_W     12    buffer address width; 2**ADDR_W >= N_PIX
// - N_OUT      5     prediction words per output beat
// - WORD_W     32    width of each prediction word
// - FIELD_LSB  4     LSB of the extracted field within each word
// - FIELD_W    8     extracted field width; FIELD_LSB+FIELD_W <= WORD_W
// - TIMEOUT    65535 watchdog limit in cycles (used only with CNN_TIMEOUT_EN)
// PORTS
// - ap_clk          in   1               clock
// - ap_rst          in   1               synchronous reset, active-high
// - job_start       in   1               request one inference (level; sampled in IDLE)
// - busy            out  1               high from job accept until result handshake
// - buf_rd_en       out  1               buffer read strobe
// - buf_rd_addr     out  ADDR_W          buffer read address
// - buf_rd_data     in   8               buffer data, valid 1 cycle after buf_rd_en
// - cnn_ap_start    out  1               core start
// - cnn_ap_ready    in   1               core accepted start
// - cnn_ap_idle     in   1               core idle
// - cnn_ap_done     in   1               core done (status only)
// - cnn_in_tdata    out  8               pixel stream to core
// - cnn_in_tvalid   out  1               pixel valid
// - cnn_in_tready   in   1               core accepts pixel
// - cnn_out_tdata   in   N_OUT*WORD_W    prediction beat
// - cnn_out_tvalid  in   1               beat valid
// - cnn_out_tready  out  1               sequencer accepts beat
// - res_data        out  N_OUT*FIELD_W   packed fields; word k -> bits [k*FIELD_W +: FIELD_W]
// - res_valid       out  1               result valid
// - res_ready       in   1               downstream accepts result
// - err_timeout     out  1               sticky watchdog flag
// BEHAVIOUR
// - Reset: all outputs 0.
// - Reset clears FSM state, counters and any in-flight pixel/result. It is honoured in every state, including mid-stream.
// - FSM IDLE -> STREAM -> WAIT_OUT -> RESULT -> IDLE.
// - IDLE: accept the job when job_start && cnn_ap_idle.
//   - Same edge: busy<=1, cnn_ap_start<=1, pixel count<=0, go to STREAM.
//   - job_start without cnn_ap_idle waits; it is neither dropped nor queued.
// - cnn_ap_start stays high until cnn_ap_ready is sampled high, then drops next cycle.
//   - cnn_ap_ready may arrive in any state before RESULT.
// - STREAM: pixels are sent at addresses 0..N_PIX-1, in order, each exactly once.
//   - cnn_in_tdata/tvalid are held stable while tready=0.
//   - Pipelined reads with a 1-entry skid give 1 pixel/cycle at full tready.
//   - First tvalid appears 2 cycles after job accept.
//   - After the N_PIX-th handshake: tvalid<=0, go to WAIT_OUT.
// - Output capture: cnn_out_tready=1 in STREAM and WAIT_OUT, 0 otherwise.
//   - On a capture handshake, res_data<=fields cnn_out_tdata[k*WORD_W+FIELD_LSB +: FIELD_W].
//   - Capture during STREAM sets a flag; the FSM still finishes streaming, then goes WAIT_OUT -> RESULT without waiting.
// - WAIT_OUT: go to RESULT once a beat is captured (or was already captured).
// - RESULT: res_valid=1 and res_data stable until res_ready.
//   - On handshake: res_valid<=0, busy<=0, go to IDLE.
//   - A new job cannot be accepted in the same cycle.
// - Beats arriving in IDLE/RESULT are not accepted (tready=0).
// - cnn_ap_done does not affect the FSM.
// CONFIGURATION
// - CNN_TIMEOUT_EN defined:
//   - A cycle counter runs in STREAM/WAIT_OUT and clears on each pixel or output handshake.
//   - When it reaches TIMEOUT: err_timeout<=1 (sticky until ap_rst), all stream valids/readies drop, cnn_ap_start<=0, busy<=0, go to IDLE with no res_valid.
// - CNN_TIMEOUT_EN undefined: no counter; err_timeout tied 0; the FSM waits indefinitely.
// TESTING
// - Nominal: buffer[i]=i[7:0], tready=1, beat word k=k<<4.
//   - Expect exactly 2304 pixel handshakes, data 0x00..0xFF repeating, 1/cycle.
//   - Expect res_data field k = k; res_valid held until res_ready.
// - Backpressure: cnn_in_tready random 50%.
//   - Expect the pixel sequence intact: no gaps, no duplicates, data stable while tready=0.
// - Early output: beat arrives after pixel 1000.
//   - Expect the beat captured, streaming still reaching 2304, then RESULT entered directly.
// - Idle gating and ap_ready: job_start high with cnn_ap_idle=0 for 10 cycles -> nothing starts.
//   - Then idle=1 -> accepted next edge.
//   - cnn_ap_start stays high until ap_ready, with ap_ready delayed 20 cycles.
// - Reset mid-stream: assert ap_rst at pixel 500.
//   - Expect all outputs 0 next cycle.
//   - The following job restarts from address 0.
// - Timeout (CNN_TIMEOUT_EN, TIMEOUT=100): never drive cnn_out_tvalid.
//   - Expect err_timeout=1 100 cycles after the last pixel, busy=0, res_valid never asserted.

Source files
------------

// File: rtl/cnn_inference_sequencer.sv
// Job sequencer for the HLS CNN core: start, stream one crop, capture and hold the prediction.
// Optional watchdog enabled by defining CNN_TIMEOUT_EN.
module cnn_inference_sequencer #(
    parameter int N_PIX     = 2304,
    parameter int ADDR_W    = 12,
    parameter int N_OUT     = 5,
    parameter int WORD_W    = 32,
    parameter int FIELD_LSB = 4,
    parameter int FIELD_W   = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      job_start,
    output logic                      busy,
    output logic                      buf_rd_en,
    output logic [ADDR_W-1:0]         buf_rd_addr,
    input  logic [7:0]                buf_rd_data,
    output logic                      cnn_ap_start,
    input  logic                      cnn_ap_ready,
    input  logic                      cnn_ap_idle,
    input  logic                      cnn_ap_done,
    output logic [7:0]                cnn_in_tdata,
    output logic                      cnn_in_tvalid,
    input  logic                      cnn_in_tready,
    input  logic [N_OUT*WORD_W-1:0]   cnn_out_tdata,
    input  logic                      cnn_out_tvalid,
    output logic                      cnn_out_tready,
    output logic [N_OUT*FIELD_W-1:0]  res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      err_timeout
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_OUT, RESULT} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] px_cnt;
    logic             pend;
    logic             skid_valid;
    logic [7:0]       skid_data;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             captured;
    logic             accept;
    logic             pop;
    logic             last_px;
    logic             cap;
    logic             rd_issue;
    logic             res_hs;
    logic             timeout_hit;
    logic [1:0]       occ;
    logic             unused_ok;

    assign accept         = (state == IDLE) && job_start && cnn_ap_idle;
    assign pop            = out_valid && cnn_in_tready;
    assign last_px        = pop && (px_cnt == CNT_W'(N_PIX - 1));
    assign cnn_out_tready = (state == STREAM) || (state == WAIT_OUT);
    assign cap            = cnn_out_tvalid && cnn_out_tready;
    assign res_hs         = res_valid && res_ready;

    // Entries held or in flight after this cycle; a new read needs a free slot.
    assign occ = {1'b0, out_valid} + {1'b0, skid_valid}
               + {1'b0, pend} - {1'b0, pop};

    assign rd_issue = (state == STREAM) && (rd_cnt < CNT_W'(N_PIX))
                    && (occ < 2'd2) && !timeout_hit;

    assign buf_rd_en     = rd_issue;
    assign buf_rd_addr   = rd_cnt[ADDR_W-1:0];
    assign cnn_in_tvalid = out_valid;
    assign cnn_in_tdata  = out_data;
    assign unused_ok     = ^{cnn_ap_done, cnn_out_tdata, TIMEOUT != 0};

`ifdef CNN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            watching;

    assign watching    = (state == STREAM) || (state == WAIT_OUT);
    assign timeout_hit = watching && !pop && !cap
                       && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign err_timeout = err_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept || pop || cap || timeout_hit) begin
                wd_cnt <= '0;
            end else if (watching) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = STREAM;
            end
            STREAM: begin
                if (timeout_hit)  state_next = IDLE;
                else if (last_px) state_next = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (timeout_hit)          state_next = IDLE;
                else if (captured || cap) state_next = RESULT;
            end
            RESULT: begin
                if (res_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            busy         <= 1'b0;
            cnn_ap_start <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            rd_cnt       <= '0;
            px_cnt       <= '0;
            pend         <= 1'b0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            captured     <= 1'b0;
        end else begin
            pend <= rd_issue;
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            if (pop)      px_cnt <= px_cnt + 1'b1;

            // Output register refills from the skid first to keep order.
            if (!out_valid || pop) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= pend;
                    if (pend) skid_data <= buf_rd_data;
                end else begin
                    out_valid <= pend;
                    if (pend) out_data <= buf_rd_data;
                end
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_data  <= buf_rd_data;
            end

            if (cap) begin
                captured <= 1'b1;
                for (int k = 0; k < N_OUT; k++) begin
                    res_data[k*FIELD_W +: FIELD_W] <=
                        cnn_out_tdata[k*WORD_W + FIELD_LSB +: FIELD_W];
                end
            end

            if (cnn_ap_start && cnn_ap_ready) cnn_ap_start <= 1'b0;

            if (state != RESULT && state_next == RESULT) res_valid <= 1'b1;

            if (res_hs) begin
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end

            if (accept) begin
                busy         <= 1'b1;
                cnn_ap_start <= 1'b1;
                rd_cnt       <= '0;
                px_cnt       <= '0;
                captured     <= 1'b0;
                pend         <= 1'b0;
                skid_valid   <= 1'b0;
                out_valid    <= 1'b0;
            end

            if (timeout_hit) begin
                busy         <= 1'b0;
                cnn_ap_start <= 1'b0;
                pend         <= 1'b0;
                skid_valid   <= 1'b0;
                out_valid    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// Self-checking bench for cnn_inference_sequencer; a job-level model is compared every cycle.
// Define CNN_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=100.
`timescale 1ns/1ps
module tb_cnn_inference_sequencer;
    localparam int N_PIX     = 2304;
    localparam int ADDR_W    = 12;
    localparam int N_OUT     = 5;
    localparam int WORD_W    = 32;
    localparam int FIELD_LSB = 4;
    localparam int FIELD_W   = 8;
`ifdef CNN_TIMEOUT_EN
    localparam int TIMEOUT   = 100;
`else
    localparam int TIMEOUT   = 65535;
`endif
    localparam int RW = N_OUT * FIELD_W;
    localparam int BW = N_OUT * WORD_W;

    logic              ap_clk;
    logic              ap_rst;
    logic              job_start;
    logic              busy;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [7:0]        buf_rd_data;
    logic              cnn_ap_start;
    logic              cnn_ap_ready;
    logic              cnn_ap_idle;
    logic              cnn_ap_done;
    logic [7:0]        cnn_in_tdata;
    logic              cnn_in_tvalid;
    logic              cnn_in_tready;
    logic [BW-1:0]     cnn_out_tdata;
    logic              cnn_out_tvalid;
    logic              cnn_out_tready;
    logic [RW-1:0]     res_data;
    logic              res_valid;
    logic              res_ready;
    logic              err_timeout;

    cnn_inference_sequencer #(
        .N_PIX(N_PIX), .ADDR_W(ADDR_W), .N_OUT(N_OUT), .WORD_W(WORD_W),
        .FIELD_LSB(FIELD_LSB), .FIELD_W(FIELD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .job_start(job_start), .busy(busy),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .cnn_ap_start(cnn_ap_start), .cnn_ap_ready(cnn_ap_ready),
        .cnn_ap_idle(cnn_ap_idle), .cnn_ap_done(cnn_ap_done),
        .cnn_in_tdata(cnn_in_tdata), .cnn_in_tvalid(cnn_in_tvalid),
        .cnn_in_tready(cnn_in_tready), .cnn_out_tdata(cnn_out_tdata),
        .cnn_out_tvalid(cnn_out_tvalid), .cnn_out_tready(cnn_out_tready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .err_timeout(err_timeout)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    // Frame buffer: one-cycle read latency.
    logic [7:0] mem [2**ADDR_W];
    initial begin
        buf_rd_data = '0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 8'(i);
    end
    always @(posedge ap_clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

    // Core handshake side: tready, delayed ap_ready, random ap_done.
    bit bp_mode     = 1'b0;
    int ready_delay = 0;
    initial begin
        int st_cnt;
        st_cnt        = 0;
        cnn_ap_ready  = 1'b0;
        cnn_ap_done   = 1'b0;
        cnn_in_tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            cnn_in_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            cnn_ap_done   = 1'($urandom_range(0, 1));
            if (cnn_ap_start) begin
                if (st_cnt >= ready_delay) begin
                    cnn_ap_ready = 1'b1;
                end else begin
                    cnn_ap_ready = 1'b0;
                    st_cnt++;
                end
            end else begin
                cnn_ap_ready = 1'b0;
                st_cnt       = 0;
            end
        end
    end

    function automatic logic [RW-1:0] fields(input logic [BW-1:0] b);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < N_OUT; k++)
            r[k*FIELD_W +: FIELD_W] = b[k*WORD_W + FIELD_LSB +: FIELD_W];
        return r;
    endfunction

    function automatic logic [BW-1:0] make_beat(input logic [7:0] base,
                                                input logic [31:0] junk);
        logic [BW-1:0] b;
        logic [7:0]    f;
        b = '0;
        for (int k = 0; k < N_OUT; k++) begin
            f = base + 8'(k);
            b[k*WORD_W +: WORD_W] = (junk & ~32'hFF0) | {20'h0, f, 4'h0};
        end
        return b;
    endfunction

    // Job-level model, advanced once per cycle for the upcoming edge.
    bit            running = 1'b0;
    bit            m_busy, m_start, m_res, m_wait, m_cap, m_err;
    int            m_px, m_cyc, m_wd;
    logic [RW-1:0] exp_res;
    logic [7:0]    first_data, last_data, prev_data;
    bit            prev_stall;

    initial begin
        bit hs, cap, fired, was_busy;
        m_busy = 0; m_start = 0; m_res = 0; m_wait = 0; m_cap = 0; m_err = 0;
        m_px = 0; m_cyc = 0; m_wd = 0; exp_res = '0;
        first_data = '0; last_data = '0; prev_data = '0; prev_stall = 0;
        forever begin
            @(negedge ap_clk);
            if (running) begin
                check("busy", 64'(busy), 64'(m_busy));
                check("ap_start", 64'(cnn_ap_start), 64'(m_start));
                check("out_tready", 64'(cnn_out_tready), 64'(m_busy && !m_res));
                check("res_valid", 64'(res_valid), 64'(m_res));
                if (m_res) check("res_data", 64'(res_data), 64'(exp_res));
                check("err_timeout", 64'(err_timeout), 64'(m_err));
                if (!bp_mode)
                    check("in_tvalid_rate", 64'(cnn_in_tvalid),
                          64'(m_busy && m_cyc >= 2 && m_px < N_PIX));
                if (prev_stall) begin
                    check("hold_valid", 64'(cnn_in_tvalid), 64'(1));
                    check("hold_data", 64'(cnn_in_tdata), 64'(prev_data));
                end
                if (buf_rd_en)
                    check("rd_addr_range", 64'(int'(buf_rd_addr) < N_PIX), 64'(1));
                hs = cnn_in_tvalid && cnn_in_tready;
                if (hs) begin
                    check("px_in_range", 64'(m_px < N_PIX), 64'(1));
                    check("px_data", 64'(cnn_in_tdata), 64'(mem[m_px % N_PIX]));
                end

                prev_stall = cnn_in_tvalid && !cnn_in_tready;
                prev_data  = cnn_in_tdata;
                if (ap_rst) begin
                    m_busy = 0; m_start = 0; m_res = 0; m_wait = 0;
                    m_cap = 0; m_err = 0; m_px = 0; m_cyc = 0; m_wd = 0;
                    prev_stall = 0;
                end else begin
                    was_busy = m_busy;
                    fired    = 0;
                    cap      = cnn_out_tvalid && m_busy && !m_res;
                    if (m_busy) m_cyc++;
                    if (m_start && cnn_ap_ready) m_start = 0;
                    if (hs) begin
                        if (m_px == 0) first_data = cnn_in_tdata;
                        if (m_px == N_PIX - 1) last_data = cnn_in_tdata;
                        m_px++;
                    end
`ifdef CNN_TIMEOUT_EN
                    if (m_busy && !m_res) begin
                        if (hs || cap) m_wd = 0;
                        else if (m_wd == TIMEOUT - 1) begin
                            fired = 1; m_err = 1; m_busy = 0; m_start = 0;
                            m_wait = 0; m_wd = 0; prev_stall = 0;
                        end else m_wd++;
                    end
`endif
                    if (m_res && res_ready) begin
                        m_res = 0; m_busy = 0;
                    end
                    if (m_wait && (m_cap || cap) && !fired) begin
                        m_res = 1; m_wait = 0;
                    end
                    if (cap && !fired) begin
                        m_cap = 1; exp_res = fields(cnn_out_tdata);
                    end
                    if (hs && m_px == N_PIX && !fired) m_wait = 1;
                    if (!was_busy && job_start && cnn_ap_idle) begin
                        m_busy = 1; m_start = 1; m_px = 0; m_cyc = 0;
                        m_wd = 0; m_cap = 0; m_wait = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_ap_start"}, 64'(cnn_ap_start), 64'(0));
        check({tag, "_rd_en"}, 64'(buf_rd_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(buf_rd_addr), 64'(0));
        check({tag, "_tvalid"}, 64'(cnn_in_tvalid), 64'(0));
        check({tag, "_tdata"}, 64'(cnn_in_tdata), 64'(0));
        check({tag, "_out_tready"}, 64'(cnn_out_tready), 64'(0));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        check({tag, "_res_data"}, 64'(res_data), 64'(0));
        check({tag, "_err"}, 64'(err_timeout), 64'(0));
    endtask

    task automatic start_job();
        int n;
        n = 0;
        job_start = 1'b1;
        do begin
            tick();
            n++;
        end while (!m_busy && n < 50);
        job_start = 1'b0;
        check("job_accept", 64'(busy), 64'(1));
    endtask

    task automatic wait_px(input int target, input int budget);
        int n;
        n = 0;
        while (m_px < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_px", 64'(m_px >= target), 64'(1));
    endtask

    task automatic send_beat(input logic [BW-1:0] b);
        bit done;
        done = 0;
        cnn_out_tdata  = b;
        cnn_out_tvalid = 1'b1;
        for (int n = 0; n < 5000 && !done; n++) begin
            @(negedge ap_clk);
            done = cnn_out_tready;
            tick();
        end
        cnn_out_tvalid = 1'b0;
        cnn_out_tdata  = ~b;
        check("beat_taken", 64'(done), 64'(1));
    endtask

    task automatic take_result(input int hold, output logic [RW-1:0] got);
        int n;
        n = 0;
        while (!res_valid && n < 10000) begin
            tick();
            n++;
        end
        check("res_arrived", 64'(res_valid), 64'(1));
        repeat (hold) tick();
        got = res_data;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_released", 64'(res_valid), 64'(0));
        check("busy_released", 64'(busy), 64'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] got;
        int n;
        job_start      = 1'b0;
        cnn_ap_idle    = 1'b1;
        cnn_out_tvalid = 1'b0;
        cnn_out_tdata  = '0;
        res_ready      = 1'b0;
        ap_rst         = 1'b1;
        repeat (3) tick();
        running = 1'b1;
        check_all_zero("reset");
        ap_rst = 1'b0;
        tick();

        // Nominal: full rate, field k = k.
        start_job();
        wait_px(N_PIX, 3000);
        send_beat(make_beat(8'h00, 32'h0));
        take_result(5, got);
        check("nominal_res", 64'(got), 64'h04_03_02_01_00);
        check("nominal_px_total", 64'(m_px), 64'(2304));
        check("nominal_first_px", 64'(first_data), 64'h00);
        check("nominal_last_px", 64'(last_data), 64'hFF);
        repeat (3) tick();

        // Backpressure: random tready.
        bp_mode = 1'b1;
        start_job();
        wait_px(N_PIX, 20000);
        send_beat(make_beat(8'h30, 32'hA5A5_A00F));
        take_result(3, got);
        check("bp_res", 64'(got), 64'h34_33_32_31_30);
        check("bp_px_total", 64'(m_px), 64'(2304));
        bp_mode = 1'b0;
        repeat (3) tick();

        // Early output beat during streaming.
        start_job();
        wait_px(1000, 2000);
        send_beat(make_beat(8'h50, 32'hFFF0_000F));
        check("early_beat_in_stream", 64'(m_px < N_PIX), 64'(1));
        take_result(2, got);
        check("early_res", 64'(got), 64'h54_53_52_51_50);
        check("early_px_total", 64'(m_px), 64'(2304));
        repeat (3) tick();

        // Idle gating, then delayed ap_ready.
        cnn_ap_idle = 1'b0;
        job_start   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("gated_busy", 64'(busy), 64'(0));
            check("gated_start", 64'(cnn_ap_start), 64'(0));
        end
        ready_delay = 20;
        cnn_ap_idle = 1'b1;
        tick();
        job_start = 1'b0;
        check("idle_accept_busy", 64'(busy), 64'(1));
        check("idle_accept_start", 64'(cnn_ap_start), 64'(1));
        repeat (15) tick();
        check("start_held", 64'(cnn_ap_start), 64'(1));
        repeat (10) tick();
        check("start_dropped", 64'(cnn_ap_start), 64'(0));
        wait_px(N_PIX, 3000);
        send_beat(make_beat(8'hA0, 32'h0));
        take_result(1, got);
        check("gated_res", 64'(got), 64'hA4_A3_A2_A1_A0);
        ready_delay = 0;
        repeat (3) tick();

        // Reset mid-stream, then a clean job from address 0.
        start_job();
        wait_px(500, 1000);
        ap_rst = 1'b1;
        tick();
        check_all_zero("midrst");
        ap_rst = 1'b0;
        tick();
        start_job();
        wait_px(N_PIX, 3000);
        check("restart_first_px", 64'(first_data), 64'h00);
        send_beat(make_beat(8'hC8, 32'h1234_500A));
        take_result(2, got);
        check("restart_res", 64'(got), 64'hCC_CB_CA_C9_C8);
        repeat (3) tick();

`ifdef CNN_TIMEOUT_EN
        // Watchdog: no output beat ever arrives.
        start_job();
        wait_px(N_PIX, 3000);
        n = 0;
        while (!err_timeout && n < 300) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(100));
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_res_valid", 64'(res_valid), 64'(0));
        repeat (10) tick();
        check("timeout_sticky", 64'(err_timeout), 64'(1));
`else
        n = 0;
        check("no_watchdog_err", 64'(err_timeout), 64'(n));
`endif

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
